ux607_mrom_icb_ctrl: RTL and testbench

ICB slave front-end for the 32-bit mask ROM on the UX607 64-bit system bus. It accepts ICB commands, drives the ROM word address, and assembles two consecutive 32-bit ROM words into one 64-bit read response. Writes get an error response. The block sits directly upstream of the mask ROM: it produces `rom_addr` and consumes `rom_dout`, with the bus fabric's ROM decode port in front of it.

---
 rtl/ux607_mrom_icb_ctrl.sv | 120 ++++++++++++
 tb/tb_ux607_mrom_icb_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ux607_mrom_icb_ctrl.sv
// ICB slave front-end for the 32-bit mask ROM: each 64-bit read is built from two
// consecutive ROM words, writes get an error response, and responses queue in a 2-entry FIFO.
module ux607_mrom_icb_ctrl #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [31:0]   icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [63:0]   icb_cmd_wdata,
  input  logic [7:0]    icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [63:0]   icb_rsp_rdata,
  output logic          icb_rsp_err,
  output logic [AW-3:0] rom_addr,
  input  logic [31:0]   rom_dout
);

  localparam int unsigned LW = AW - 3;

  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI} state_e;

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } rsp_t;

  state_e        state_q, state_d;
  logic [LW-1:0] line_q;
  logic [31:0]   lo_q;
  rsp_t          fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;

  logic cmd_hs, push, pop, line_en, lo_en;
  rsp_t push_data;

  logic unused_ok;
  assign unused_ok = ^{icb_cmd_addr[31:AW], icb_cmd_addr[2:0], icb_cmd_wdata, icb_cmd_wmask};

  // Ready only from registered state; a read reserves its FIFO slot at acceptance.
  assign icb_cmd_ready = (state_q == IDLE) && (count_q < 2'd2);
  assign cmd_hs        = icb_cmd_valid && icb_cmd_ready;
  assign icb_rsp_valid = (count_q != 2'd0);
  assign pop           = icb_rsp_valid && icb_rsp_ready;
  assign {icb_rsp_err, icb_rsp_rdata} = icb_rsp_valid ? fifo_q[rd_ptr_q] : '0;

  // Next-state, ROM addressing and FIFO push.
  always_comb begin
    state_d   = state_q;
    rom_addr  = '0;
    push      = 1'b0;
    push_data = '0;
    line_en   = 1'b0;
    lo_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          if (icb_cmd_read) begin
            line_en = 1'b1;
            state_d = FETCH_LO;
          end else begin
            push          = 1'b1;
            push_data.err = 1'b1;
          end
        end
      end
      FETCH_LO: begin
        rom_addr = {line_q, 1'b0};
        lo_en    = 1'b1;
        state_d  = FETCH_HI;
      end
      FETCH_HI: begin
        rom_addr        = {line_q, 1'b1};
        push            = 1'b1;
        push_data.rdata = {rom_dout, lo_q};
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      line_q  <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (line_en) line_q <= icb_cmd_addr[AW-1:3];
      if (lo_en)   lo_q   <= rom_dout;
    end
  end

  // Response FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ux607_mrom_icb_ctrl.sv
// Directed scenarios plus a randomized run against a queue-based response model.
module tb_ux607_mrom_icb_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned NW = 1 << (AW - 2);
  localparam logic [63:0] BOOT = 64'h00028067_7ffff297;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [31:0]   icb_cmd_addr;
  logic          icb_cmd_read;
  logic [63:0]   icb_cmd_wdata;
  logic [7:0]    icb_cmd_wmask;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic [63:0]   icb_rsp_rdata;
  logic          icb_rsp_err;
  logic [AW-3:0] rom_addr;
  logic [31:0]   rom_dout;

  logic [31:0] rom [NW];
  assign rom_dout = rom[rom_addr];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        err;
    logic [63:0] d;
  } exp_t;

  always #5 clk = ~clk;

  ux607_mrom_icb_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A read returns the 8-byte line containing the address, low word first.
  function automatic logic [63:0] line_data(input logic [31:0] addr);
    int unsigned base;
    base = ((addr % (32'd1 << AW)) / 8) * 2;
    return {rom[base + 1], rom[base]};
  endfunction

  task automatic boot_rom();
    for (int i = 0; i < NW; i++) rom[i] = 32'h0;
    rom[0] = 32'h7ffff297;
    rom[1] = 32'h00028067;
  endtask

  // Present a command, wait (bounded) for acceptance; returns in cycle T+1.
  task automatic send_cmd(input logic rd, input logic [31:0] addr, input logic [63:0] wd);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = addr;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = 8'hff;
    for (int i = 0; i < 20 && !icb_cmd_ready; i++) tick();
    total++;
    if (icb_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", icb_cmd_ready);
    end
    tick();
    icb_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %b want 1", icb_cmd_ready); end
    total++; if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", icb_rsp_valid); end
    total++; if (icb_rsp_rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", icb_rsp_rdata); end
    total++; if (icb_rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", icb_rsp_err); end
    total++; if (rom_addr !== '0) begin bad++; $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read0();
    icb_rsp_ready = 1'b1;
    send_cmd(1'b1, 32'h0, 64'h0);
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL read0_addr_t1: got %0d want 0", rom_addr); end
    total++; if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL read0_early_valid: got %b want 0", icb_rsp_valid); end
    tick();
    total++; if (rom_addr !== 10'd1) begin bad++; $display("FAIL read0_addr_t2: got %0d want 1", rom_addr); end
    total++; if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL read0_valid_t2: got %b want 0", icb_rsp_valid); end
    tick();
    total++; if (icb_rsp_valid !== 1'b1) begin bad++; $display("FAIL read0_valid_t3: got %b want 1", icb_rsp_valid); end
    total++; if (icb_rsp_rdata !== BOOT) begin bad++; $display("FAIL read0_rdata: got %h want %h", icb_rsp_rdata, BOOT); end
    total++; if (icb_rsp_err !== 1'b0) begin bad++; $display("FAIL read0_err: got %b want 0", icb_rsp_err); end
    total++; if (icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL read0_ready_t3: got %b want 1", icb_cmd_ready); end
    tick();
    total++; if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL read0_popped: got %b want 0", icb_rsp_valid); end
  endtask

  task automatic test_read_pair();
    icb_rsp_ready = 1'b1;
    send_cmd(1'b1, 32'h4, 64'h0);
    tick();
    tick();
    total++; if (icb_rsp_rdata !== BOOT || icb_rsp_valid !== 1'b1) begin bad++; $display("FAIL pair_first: got v=%b %h want v=1 %h", icb_rsp_valid, icb_rsp_rdata, BOOT); end
    send_cmd(1'b1, 32'h8, 64'h0);
    total++; if (rom_addr !== 10'd2) begin bad++; $display("FAIL pair_addr_lo: got %0d want 2", rom_addr); end
    tick();
    total++; if (rom_addr !== 10'd3) begin bad++; $display("FAIL pair_addr_hi: got %0d want 3", rom_addr); end
    tick();
    total++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 64'h0) begin bad++; $display("FAIL pair_second: got v=%b %h want v=1 0", icb_rsp_valid, icb_rsp_rdata); end
    tick();
  endtask

  task automatic test_write();
    icb_rsp_ready = 1'b1;
    send_cmd(1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    total++; if (icb_rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_valid: got %b want 1", icb_rsp_valid); end
    total++; if (icb_rsp_err !== 1'b1) begin bad++; $display("FAIL wr_err: got %b want 1", icb_rsp_err); end
    total++; if (icb_rsp_rdata !== 64'h0) begin bad++; $display("FAIL wr_rdata: got %h want 0", icb_rsp_rdata); end
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL wr_rom_addr_t1: got %0d want 0", rom_addr); end
    tick();
    total++; if (rom_addr !== 10'd0) begin bad++; $display("FAIL wr_rom_addr_t2: got %0d want 0", rom_addr); end
    total++; if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_popped: got %b want 0", icb_rsp_valid); end
  endtask

  task automatic test_back_to_back_writes();
    icb_rsp_ready = 1'b1;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = 32'h10;
    for (int i = 0; i < 4; i++) begin
      total++; if (icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_wr_ready[%0d]: got %b want 1", i, icb_cmd_ready); end
      tick();
      total++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b1) begin bad++; $display("FAIL b2b_wr_rsp[%0d]: got v=%b e=%b want 1 1", i, icb_rsp_valid, icb_rsp_err); end
    end
    icb_cmd_valid = 1'b0;
    tick();
  endtask

  task automatic test_full();
    icb_rsp_ready = 1'b0;
    send_cmd(1'b0, 32'h0, 64'h0);
    send_cmd(1'b1, 32'h0, 64'h0);
    tick();
    tick();
    total++; if (icb_cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", icb_cmd_ready); end
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (icb_cmd_ready !== 1'b0 || rom_addr !== 10'd0) begin bad++; $display("FAIL full_stall[%0d]: got ready=%b rom_addr=%0d want 0 0", i, icb_cmd_ready, rom_addr); end
      total++; if (icb_rsp_err !== 1'b1 || icb_rsp_valid !== 1'b1) begin bad++; $display("FAIL full_hold[%0d]: got v=%b e=%b want 1 1", i, icb_rsp_valid, icb_rsp_err); end
    end
    icb_rsp_ready = 1'b1;
    total++; if (icb_rsp_err !== 1'b1 || icb_rsp_rdata !== 64'h0) begin bad++; $display("FAIL full_rsp1: got e=%b %h want e=1 0", icb_rsp_err, icb_rsp_rdata); end
    tick();
    total++; if (icb_rsp_err !== 1'b0 || icb_rsp_rdata !== BOOT || icb_rsp_valid !== 1'b1) begin bad++; $display("FAIL full_rsp2: got v=%b e=%b %h want 1 0 %h", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata, BOOT); end
    total++; if (icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL full_ready_again: got %b want 1", icb_cmd_ready); end
    tick();
    icb_cmd_valid = 1'b0;
    total++; if (icb_rsp_valid !== 1'b0 || rom_addr !== 10'd2) begin bad++; $display("FAIL full_third_lo: got v=%b rom_addr=%0d want 0 2", icb_rsp_valid, rom_addr); end
    tick();
    total++; if (rom_addr !== 10'd3) begin bad++; $display("FAIL full_third_hi: got %0d want 3", rom_addr); end
    tick();
    total++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0 || icb_rsp_rdata !== 64'h0) begin bad++; $display("FAIL full_rsp3: got v=%b e=%b %h want 1 0 0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    icb_rsp_ready = 1'b1;
    send_cmd(1'b1, 32'h0, 64'h0);
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (icb_cmd_ready !== 1'b1 || icb_rsp_valid !== 1'b0 || rom_addr !== 10'd0) begin bad++; $display("FAIL midrst_outputs: got ready=%b v=%b rom_addr=%0d want 1 0 0", icb_cmd_ready, icb_rsp_valid, rom_addr); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_ghost[%0d]: got %b want 0", i, icb_rsp_valid); end
      tick();
    end
    total++; if (icb_cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", icb_cmd_ready); end
    send_cmd(1'b1, 32'h0, 64'h0);
    tick();
    total++; if (icb_rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_early: got %b want 0", icb_rsp_valid); end
    tick();
    total++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== BOOT) begin bad++; $display("FAIL midrst_reread: got v=%b %h want 1 %h", icb_rsp_valid, icb_rsp_rdata, BOOT); end
    tick();
  endtask

  task automatic test_last_line();
    icb_rsp_ready = 1'b1;
    send_cmd(1'b1, (32'd1 << AW) - 32'd8, 64'h0);
    total++; if (rom_addr !== 10'(NW - 2)) begin bad++; $display("FAIL last_lo: got %0d want %0d", rom_addr, NW - 2); end
    tick();
    total++; if (rom_addr !== 10'(NW - 1)) begin bad++; $display("FAIL last_hi: got %0d want %0d", rom_addr, NW - 1); end
    tick();
    total++; if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 64'h0) begin bad++; $display("FAIL last_rdata: got v=%b %h want 1 0", icb_rsp_valid, icb_rsp_rdata); end
    tick();
  endtask

  // Random traffic: expected responses queue in acceptance order; a read appears 3 cycles after acceptance.
  task automatic test_random();
    exp_t q[$];
    exp_t got;
    int   busy = 0;
    int   delivered;
    for (int i = 0; i < NW; i++) rom[i] = $urandom;
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (busy > 0) busy--;
      delivered = q.size() - ((busy != 0) ? 1 : 0);
      total++; if (icb_cmd_ready !== ((busy == 0) && (q.size() < 2))) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, icb_cmd_ready, (busy == 0) && (q.size() < 2)); end
      total++; if (icb_rsp_valid !== (delivered != 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, icb_rsp_valid, delivered != 0); end
      if (!icb_rsp_valid) begin
        total++; if (icb_rsp_rdata !== 64'h0 || icb_rsp_err !== 1'b0) begin bad++; $display("FAIL rnd_empty_out@%0d: got e=%b %h want 0 0", cyc, icb_rsp_err, icb_rsp_rdata); end
      end
      icb_cmd_valid = 1'($urandom_range(0, 1));
      icb_cmd_read  = ($urandom_range(0, 3) != 0);
      icb_cmd_addr  = $urandom;
      icb_cmd_wdata = {$urandom, $urandom};
      icb_cmd_wmask = 8'($urandom);
      icb_rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (icb_rsp_valid && icb_rsp_ready) begin
        got = '{err: icb_rsp_err, d: icb_rsp_rdata};
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected_rsp@%0d: got e=%b %h want none", cyc, icb_rsp_err, icb_rsp_rdata);
        end else begin
          if (got !== q[0]) begin bad++; $display("FAIL rnd_rsp@%0d: got e=%b %h want e=%b %h", cyc, got.err, got.d, q[0].err, q[0].d); end
          void'(q.pop_front());
        end
      end
      if (icb_cmd_valid && icb_cmd_ready) begin
        if (icb_cmd_read) begin
          q.push_back('{err: 1'b0, d: line_data(icb_cmd_addr)});
          busy = 3;
        end else begin
          q.push_back('{err: 1'b1, d: 64'h0});
        end
      end
    end
    icb_cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = 32'h0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = 64'h0;
    icb_cmd_wmask = 8'h0;
    icb_rsp_ready = 1'b0;
    boot_rom();
    test_reset();
    test_read0();
    test_read_pair();
    test_write();
    test_back_to_back_writes();
    test_full();
    test_reset_mid_fetch();
    test_last_line();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
